// File: rtl/jtcps_obj_pkg.sv
// Shared definitions for the CPS object line-drawing engine:
// FSM state encoding, transparent colour and attribute field positions.
package jtcps_obj_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_LATCH = 2'd2,
    ST_DRAW  = 2'd3
  } obj_state_t;

  localparam logic [3:0]  TRANSP     = 4'hF;
  localparam logic [31:0] BLANK_WORD = 32'hFFFF_FFFF;

  localparam int ROW_MSB   = 11;
  localparam int ROW_LSB   = 8;
  localparam int HFLIP_BIT = 5;

endpackage

// File: rtl/jtcps_obj_pxlsh.sv
// Pixel shifter: holds one 32-bit planar ROM word (8 pixels x 4 bpp) and
// presents the colour of the current pixel. Flip selects both the read taps
// and the shift direction so the pixel order is mirrored.
module jtcps_obj_pxlsh (
  input  logic        clk,
  input  logic        load,
  input  logic        flip,
  input  logic        shift,
  input  logic [31:0] din,
  output logic [3:0]  colour
);

  logic [31:0] sr;

  // Load a fresh word, or move the next pixel onto the read taps (fill with 1s)
  always_ff @(posedge clk) begin
    if (load)
      sr <= din;
    else if (shift)
      sr <= flip ? {1'b1, sr[31:1]} : {sr[30:0], 1'b1};
  end

  assign colour = flip ? {sr[24], sr[16], sr[8], sr[0]}
                       : {sr[31], sr[23], sr[15], sr[7]};

endmodule

// File: rtl/jtcps_obj_draw_gen.sv
// Object line-drawing engine: fetches WORDS ROM words per object row and
// writes palette-tagged, non-transparent pixels to consecutive line-buffer
// addresses. Optional feature macro: JTCPS_OBJ_BLANKSKIP_EN (all-transparent
// words skip the 8 drawing cycles).
module jtcps_obj_draw_gen
  import jtcps_obj_pkg::*;
#(
  parameter int AW    = 9,
  parameter int PALW  = 5,
  parameter int WORDS = 2,
  parameter int XMIN  = 'h30,
  parameter int XMAX  = 'h1c0
)(
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic [15:0]                           obj_code,
  input  logic [15:0]                           obj_attr,
  input  logic [AW-1:0]                         obj_hpos,
  input  logic [1:0]                            obj_bank,
  input  logic                                  start,
  output logic                                  idle,
  output logic [AW-1:0]                         buf_addr,
  output logic [PALW+3:0]                       buf_data,
  output logic                                  buf_wr,
  output logic [19:0]                           rom_addr,
  output logic [1:0]                            rom_bank,
  output logic [((WORDS > 1) ? $clog2(WORDS) : 1)-1:0] rom_sub,
  output logic                                  rom_cs,
  input  logic [31:0]                           rom_data,
  input  logic                                  rom_ok
);

  localparam int SUBW = (WORDS > 1) ? $clog2(WORDS) : 1;

  obj_state_t      state, state_nx;
  logic [SUBW-1:0] k;
  logic            wait_cnt;
  logic [2:0]      px;
  logic [AW-1:0]   hpos;
  logic [AW-1:0]   addr_base;
  logic [PALW-1:0] pal;
  logic            hflip;
  logic [1:0]      bank;
  logic [3:0]      colour;
  logic            accept, last_word, last_px, blank_skip, load, shift;
  logic            attr_unused;

  assign attr_unused = &{1'b0, obj_attr};

  assign accept    = start && (obj_hpos > AW'(XMIN)) && (obj_hpos < AW'(XMAX));
  assign last_word = (k == SUBW'(WORDS - 1));
  assign last_px   = (px == 3'd7);
  assign addr_base = (k == '0) ? hpos : buf_addr;

`ifdef JTCPS_OBJ_BLANKSKIP_EN
  assign blank_skip = (rom_data == BLANK_WORD);
`else
  assign blank_skip = 1'b0;
`endif

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: 2-cycle ROM settle, wait for data, then 8 pixels per word
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE:  if (accept) state_nx = ST_WAIT;
      ST_WAIT:  if (wait_cnt) state_nx = ST_LATCH;
      ST_LATCH: if (rom_ok) begin
                  if (blank_skip) state_nx = last_word ? ST_IDLE : ST_WAIT;
                  else            state_nx = ST_DRAW;
                end
      ST_DRAW:  if (last_px) state_nx = last_word ? ST_IDLE : ST_WAIT;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Control and visible address counters; cleared on reset so outputs start at 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      k        <= '0;
      wait_cnt <= 1'b0;
      px       <= 3'd0;
      rom_addr <= 20'd0;
      buf_addr <= '0;
    end else begin
      case (state)
        ST_IDLE: if (accept) begin
          rom_addr <= {obj_code, obj_attr[ROW_MSB:ROW_LSB]};
          k        <= '0;
          wait_cnt <= 1'b0;
        end
        ST_WAIT: wait_cnt <= ~wait_cnt;
        ST_LATCH: if (rom_ok) begin
          px <= 3'd0;
          if (blank_skip) begin
            buf_addr <= addr_base + AW'(8);
            if (!last_word) k <= k + SUBW'(1);
          end else begin
            buf_addr <= addr_base;
          end
        end
        ST_DRAW: begin
          buf_addr <= buf_addr + AW'(1);
          px       <= px + 3'd1;
          if (last_px && !last_word) k <= k + SUBW'(1);
        end
        default: ;
      endcase
    end
  end

  // Object parameters captured on accept; only observed while busy
  always_ff @(posedge clk) begin
    if (state == ST_IDLE && accept) begin
      hpos  <= obj_hpos;
      pal   <= obj_attr[PALW-1:0];
      hflip <= obj_attr[HFLIP_BIT];
      bank  <= obj_bank;
    end
  end

  assign load  = (state == ST_LATCH) && rom_ok;
  assign shift = (state == ST_DRAW);

  jtcps_obj_pxlsh u_pxlsh (
    .clk    (clk),
    .load   (load),
    .flip   (hflip),
    .shift  (shift),
    .din    (rom_data),
    .colour (colour)
  );

  assign idle     = (state == ST_IDLE);
  assign rom_cs   = (state != ST_IDLE);
  assign rom_bank = rom_cs ? bank : 2'd0;
  assign rom_sub  = rom_cs ? (hflip ? SUBW'(WORDS - 1) - k : k) : '0;
  assign buf_wr   = (state == ST_DRAW) && (colour != TRANSP);
  assign buf_data = (state == ST_DRAW) ? {pal, colour} : '0;

endmodule

// File: tb/tb_jtcps_obj_draw_gen.sv
// Bench for jtcps_obj_draw_gen: directed and randomized objects against a
// behavioural model of pixel order, addresses, ROM word order and duration.
module tb_jtcps_obj_draw_gen;
  localparam int AW = 9, PALW = 5, WORDS = 2;
`ifdef JTCPS_OBJ_BLANKSKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic clk = 1'b0, rst = 1'b1;
  logic [15:0] obj_code = '0, obj_attr = '0;
  logic [AW-1:0] obj_hpos = '0;
  logic [1:0] obj_bank = '0;
  logic start = 1'b0;
  logic idle, buf_wr, rom_cs;
  logic [AW-1:0] buf_addr;
  logic [PALW+3:0] buf_data;
  logic [19:0] rom_addr;
  logic [1:0] rom_bank;
  logic [0:0] rom_sub;
  logic [31:0] rom_data = '0;
  logic rom_ok = 1'b0;

  int errors = 0, checks = 0;

  typedef struct packed { logic [AW-1:0] a; logic [PALW+3:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t log_q[$];
  wr_t e_cur;
  int sub_log[$];
  logic [31:0] words [WORDS];
  int lat = 0, age = 0;
  logic [20:0] prev_key = '0;
  logic prev_cs = 1'b0;
  logic chk_en = 1'b0;
  logic [19:0] exp_rom_addr = '0;
  logic [1:0] exp_bank = '0;

  always #5 clk = ~clk;

  jtcps_obj_draw_gen #(.AW(AW), .PALW(PALW), .WORDS(WORDS), .XMIN('h30), .XMAX('h1c0)) dut (
    .clk(clk), .rst(rst), .obj_code(obj_code), .obj_attr(obj_attr), .obj_hpos(obj_hpos),
    .obj_bank(obj_bank), .start(start), .idle(idle), .buf_addr(buf_addr), .buf_data(buf_data),
    .buf_wr(buf_wr), .rom_addr(rom_addr), .rom_bank(rom_bank), .rom_sub(rom_sub), .rom_cs(rom_cs),
    .rom_data(rom_data), .rom_ok(rom_ok)
  );

  function automatic logic [3:0] pix(input logic [31:0] d, input logic fl, input int i);
    if (fl) return {d[24+i], d[16+i], d[8+i], d[i]};
    return {d[31-i], d[23-i], d[15-i], d[7-i]};
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, got, want);
    end
  endtask

  // ROM model: data follows rom_sub; rom_ok rises lat cycles after the address settles
  always @(negedge clk) begin
    if (rom_cs && prev_cs && ({rom_sub, rom_addr} == prev_key)) age = age + 1;
    else begin
      age = 0;
      if (rom_cs) sub_log.push_back(int'(rom_sub));
    end
    prev_cs  = rom_cs;
    prev_key = {rom_sub, rom_addr};
    rom_ok   = (age >= lat);
    rom_data = words[rom_sub];
  end

  // Compare process: every ROM access and every line-buffer write
  always @(negedge clk) begin
    if (chk_en) begin
      if (rom_cs === 1'b1) begin
        checks++;
        if ({rom_bank, rom_addr} !== {exp_bank, exp_rom_addr}) begin
          errors++;
          $display("FAIL rom_addr: got %h/%h want %h/%h", rom_bank, rom_addr, exp_bank, exp_rom_addr);
        end
      end
      if (buf_wr === 1'b1) begin
        checks++;
        log_q.push_back({buf_addr, buf_data});
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected: got addr %h data %h want none", buf_addr, buf_data);
        end else begin
          e_cur = exp_q.pop_front();
          if ({buf_addr, buf_data} !== e_cur) begin
            errors++;
            $display("FAIL write: got addr %h data %h want addr %h data %h", buf_addr, buf_data, e_cur.a, e_cur.d);
          end
        end
      end else if (buf_wr !== 1'b0) begin
        checks++; errors++;
        $display("FAIL buf_wr_x: got %b want 0/1", buf_wr);
      end
    end
  end

  task automatic run_obj(input logic [15:0] code, input logic [15:0] attr, input logic [AW-1:0] hpos,
                         input logic [1:0] bank, input logic [31:0] w0, input logic [31:0] w1,
                         input int l, input bit poke, output int busy);
    int exp_cyc;
    logic fl, in_win;
    logic [31:0] d;
    words[0] = w0; words[1] = w1; lat = l;
    fl = attr[5];
    in_win = (hpos > 9'h30) && (hpos < 9'h1c0);
    exp_cyc = 0;
    if (in_win) begin
      for (int w = 0; w < WORDS; w++) begin
        d = words[fl ? WORDS-1-w : w];
        exp_cyc += 2 + ((l > 2) ? l - 1 : 1);
        if (!(SKIP && d == 32'hFFFF_FFFF)) begin
          exp_cyc += 8;
          for (int i = 0; i < 8; i++)
            if (pix(d, fl, i) != 4'hF)
              exp_q.push_back({AW'(int'(hpos) + 8*w + i), attr[PALW-1:0], pix(d, fl, i)});
        end
      end
    end
    exp_rom_addr = {code, attr[11:8]};
    exp_bank = bank;
    sub_log.delete();
    log_q.delete();
    @(negedge clk);
    obj_code = code; obj_attr = attr; obj_hpos = hpos; obj_bank = bank; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy = 0;
    while (idle !== 1'b1 && busy < 300) begin
      if (poke && busy == 4) begin start = 1'b1; obj_hpos = 9'h50; obj_code = ~code; end
      else start = 1'b0;
      busy++;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", busy, exp_cyc);
    check("missing_writes", exp_q.size(), 0);
    exp_q.delete();
    if (in_win) begin
      check("sub_count", sub_log.size(), WORDS);
      for (int w = 0; w < WORDS && w < sub_log.size(); w++)
        check("sub_order", sub_log[w], fl ? WORDS-1-w : w);
    end else begin
      check("dropped_no_cs", sub_log.size(), 0);
    end
  endtask

  function automatic logic [31:0] rnd_word();
    case ($urandom_range(0, 3))
      0: return 32'hFFFF_FFFF;
      1: return $urandom | $urandom;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int busy;
    logic [AW-1:0] hp;
    words[0] = '0; words[1] = '0;
    #1;
    check("reset_outputs", {idle, buf_wr, rom_cs, buf_addr, buf_data, rom_addr, rom_bank, rom_sub},
          {1'b1, 1'b0, 1'b0, 9'd0, 9'd0, 20'd0, 2'd0, 1'b0});
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Basic object: hpos 0x40, pal 3, no flip
    run_obj(16'h1234, 16'h0303, 9'h040, 2'd2, 32'h0123_4567, 32'h89AB_CDEF, 0, 1'b0, busy);
    check("basic_busy_lit", busy, 22);
    check("basic_nwr_lit", log_q.size(), 12);
    if (log_q.size() == 12) begin
      check("basic_wr0_lit", log_q[0], {9'h040, 9'h030});
      check("basic_wr1_lit", log_q[1], {9'h041, 9'h033});
      check("basic_wr11_lit", log_q[11], {9'h04E, 9'h035});
    end

    // Same object mirrored
    run_obj(16'h1234, 16'h0323, 9'h040, 2'd2, 32'h0123_4567, 32'h89AB_CDEF, 0, 1'b0, busy);
    if (log_q.size() > 0) check("flip_wr0_lit", log_q[0], {9'h041, 9'h035});

    // Alternating transparency
    run_obj(16'h0055, 16'h0011, 9'h080, 2'd1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 1'b0, busy);
    check("transp_nwr", log_q.size(), 8);

    // Window edges and start while busy
    run_obj(16'h0001, 16'h0001, 9'h030, 2'd0, 32'h0, 32'h0, 0, 1'b0, busy);
    run_obj(16'h0001, 16'h0001, 9'h1c0, 2'd0, 32'h0, 32'h0, 0, 1'b0, busy);
    run_obj(16'h0002, 16'h0102, 9'h031, 2'd3, 32'h0, 32'h1111_0000, 0, 1'b1, busy);
    run_obj(16'h0003, 16'h0224, 9'h1bf, 2'd1, 32'h1234_5678, 32'h0, 2, 1'b1, busy);

    // All-transparent words
    run_obj(16'h0004, 16'h0005, 9'h060, 2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0, busy);
    check("blank_nwr", log_q.size(), 0);

    // ROM stall: rom_ok low 5 cycles into LATCH on each word
    run_obj(16'h0ABC, 16'h0407, 9'h100, 2'd1, 32'h0123_4567, 32'h89AB_CDEF, 7, 1'b0, busy);
    check("stall_busy_lit", busy, 32);

    // Reset in the middle of DRAW
    chk_en = 1'b0;
    words[0] = 32'h0; words[1] = 32'h0; lat = 0;
    @(negedge clk);
    obj_code = 16'h7777; obj_attr = 16'h0001; obj_hpos = 9'h90; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    busy = 0;
    while (buf_wr !== 1'b1 && busy < 50) begin busy++; @(negedge clk); end
    check("reset_reach_draw", buf_wr, 1'b1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_mid_draw", {buf_wr, rom_cs, idle, buf_addr, rom_addr}, {1'b0, 1'b0, 1'b1, 9'd0, 20'd0});
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk_en = 1'b1;
    run_obj(16'h0321, 16'h0512, 9'h0A0, 2'd3, 32'h0123_4567, 32'h0, 0, 1'b0, busy);

    // Randomized objects
    for (int n = 0; n < 40; n++) begin
      if (n % 8 == 7)
        hp = ($urandom_range(0, 1) == 1) ? AW'($urandom_range(0, 'h30)) : AW'($urandom_range('h1c0, 'h1ff));
      else
        hp = AW'($urandom_range('h31, 'h1bf));
      run_obj(16'($urandom), 16'($urandom), hp, 2'($urandom), rnd_word(), rnd_word(),
              int'($urandom_range(0, 6)), (n % 5 == 0), busy);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish want finish");
    $fatal(1, "timeout");
  end

endmodule
